dac_serial_tx: RTL and testbench

DAC_SERIAL_TX -- requirements
Module: dac_serial_tx

---
 rtl/dac_serial_tx.sv | 184 ++++++++++++++++++
 tb/tb_dac_serial_tx.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_serial_tx.sv
// Serialises 16-bit DAC command words onto a SYNC_n/SCLK/DIN bus with a 1-deep pending slot.
// Build macro DAC_TX_CHANGE_DETECT_EN adds automatic frames whenever Data_In differs from the last word sent.
module dac_serial_tx #(
    parameter int CLK_DIV       = 4,
    parameter int SYNC_IDLE_CYC = 2
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic [15:0] Data_In,
    input  logic        Load,
    output logic        Busy,
    output logic        Done,
    output logic        Overrun,
    output logic        DAC_SCLK,
    output logic        DAC_SYNC_n,
    output logic        DAC_DIN,
    output logic [1:0]  dbg_state
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST = 8'(SYNC_IDLE_CYC - 1);
    localparam logic [4:0] HALF_LAST = 5'd31;

    logic [1:0]  state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  half_q, half_d;
    logic [15:0] shreg_q, shreg_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        sclk_q, sclk_d;
    logic        sync_n_q, sync_n_d;
    logic        din_q, din_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;
    logic        start;
    logic [15:0] start_word;
`ifdef DAC_TX_CHANGE_DETECT_EN
    logic [15:0] last_sent_q, last_sent_d;
`endif

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        half_d     = half_q;
        shreg_d    = shreg_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        sclk_d     = sclk_q;
        sync_n_d   = sync_n_q;
        din_d      = din_q;
        done_d     = 1'b0;
        overrun_d  = 1'b0;
        start      = 1'b0;
        start_word = Data_In;
`ifdef DAC_TX_CHANGE_DETECT_EN
        last_sent_d = last_sent_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A fresh Load wins over a stale pending word, which is then dropped.
                if (Load) begin
                    start      = 1'b1;
                    start_word = Data_In;
                    overrun_d  = pend_vld_q;
                    pend_vld_d = 1'b0;
                end else if (pend_vld_q) begin
                    start      = 1'b1;
                    start_word = pend_q;
                    pend_vld_d = 1'b0;
                end
`ifdef DAC_TX_CHANGE_DETECT_EN
                else if (Data_In != last_sent_q) begin
                    start      = 1'b1;
                    start_word = Data_In;
                end
`endif
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (half_q == HALF_LAST) begin
                        state_d  = ST_HOLD;
                        sync_n_d = 1'b1;
                        sclk_d   = 1'b1;
                        din_d    = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        half_d = half_q + 5'd1;
                        // Leaving an odd (low) half starts the next bit's high half.
                        sclk_d = half_q[0];
                        if (half_q[0]) begin
                            shreg_d = {shreg_q[14:0], 1'b0};
                            din_d   = shreg_q[14];
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (div_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && Load) begin
            pend_d     = Data_In;
            pend_vld_d = 1'b1;
            overrun_d  = pend_vld_q;
        end

        if (start) begin
            state_d  = ST_SHIFT;
            shreg_d  = start_word;
            din_d    = start_word[15];
            sclk_d   = 1'b1;
            sync_n_d = 1'b0;
            div_d    = '0;
            half_d   = '0;
`ifdef DAC_TX_CHANGE_DETECT_EN
            last_sent_d = start_word;
`endif
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            half_q     <= '0;
            shreg_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            sclk_q     <= 1'b1;
            sync_n_q   <= 1'b1;
            din_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            half_q     <= half_d;
            shreg_q    <= shreg_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sclk_q     <= sclk_d;
            sync_n_q   <= sync_n_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef DAC_TX_CHANGE_DETECT_EN
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            last_sent_q <= 16'hFFFF;
        end else begin
            last_sent_q <= last_sent_d;
        end
    end
`endif

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Overrun    = overrun_q;
    assign DAC_SCLK   = sclk_q;
    assign DAC_SYNC_n = sync_n_q;
    assign DAC_DIN    = din_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_dac_serial_tx.sv
// Bench for dac_serial_tx: two instances (default and fastest divider) checked cycle by cycle against
// a timing model derived from frame arithmetic, plus a bus decoder feeding a word scoreboard.
module tb_dac_serial_tx;
    localparam int DIV_A  = 4;
    localparam int HOLD_A = 2;
    localparam int DIV_B  = 1;
    localparam int HOLD_B = 1;

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp_word;
        int          exp_sync_low;
        int          exp_falls;
        int          exp_done_at;
        int          exp_busy;
    } vec_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] din_a  = 16'hFFFF;
    logic [15:0] din_b  = 16'hFFFF;
    logic        load_a = 1'b0;
    logic        load_b = 1'b0;
    logic        busy_a, done_a, ovr_a, sclk_a, sync_a, sdin_a;
    logic        busy_b, done_b, ovr_b, sclk_b, sync_b, sdin_b;
    logic [1:0]  st_a, st_b;
    logic [5:0]  o_a, o_b;

    always #5 clk = ~clk;

    dac_serial_tx #(.CLK_DIV(DIV_A), .SYNC_IDLE_CYC(HOLD_A)) dut_a (
        .CLK(clk), .RST_n(rst_n), .Data_In(din_a), .Load(load_a),
        .Busy(busy_a), .Done(done_a), .Overrun(ovr_a),
        .DAC_SCLK(sclk_a), .DAC_SYNC_n(sync_a), .DAC_DIN(sdin_a), .dbg_state(st_a)
    );

    dac_serial_tx #(.CLK_DIV(DIV_B), .SYNC_IDLE_CYC(HOLD_B)) dut_b (
        .CLK(clk), .RST_n(rst_n), .Data_In(din_b), .Load(load_b),
        .Busy(busy_b), .Done(done_b), .Overrun(ovr_b),
        .DAC_SCLK(sclk_b), .DAC_SYNC_n(sync_b), .DAC_DIN(sdin_b), .dbg_state(st_b)
    );

    assign o_a = {busy_a, done_a, ovr_a, sync_a, sclk_a, sdin_a};
    assign o_b = {busy_b, done_b, ovr_b, sync_b, sclk_b, sdin_b};

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    // Reference model: remaining busy cycles of the current frame plus the pending slot.
    int          div_m = DIV_A;
    int          hold_m = HOLD_A;
    int          rem = 0;
    logic        pend_v = 1'b0;
    logic [15:0] pend_w = '0;
    logic [15:0] cur_w = '0;
    logic [15:0] last_sent_m = 16'hFFFF;
    logic        exp_ovr = 1'b0;
    logic [15:0] exp_q[$];

    logic        prev_sclk = 1'b1;
    logic        prev_sync = 1'b1;
    logic [15:0] rx_w = '0;
    logic [15:0] last_rx = '0;
    int          rx_cnt = 0;
    int          frames = 0;
    int          busy_seen = 0;
    int          ovr_seen = 0;
    logic        s_busy, s_done, s_ovr, s_sync, s_sclk, s_din, s_fell;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, expv);
        end
    endtask

    task automatic start_frame(input logic [15:0] w);
        rem         = 32 * div_m + hold_m;
        cur_w       = w;
        last_sent_m = w;
        exp_q.push_back(w);
    endtask

    task automatic model_edge(input logic ld, input logic [15:0] d);
        logic ovr;
        ovr = 1'b0;
        if (rem == 0) begin
            if (ld) begin
                ovr    = pend_v;
                pend_v = 1'b0;
                start_frame(d);
            end else if (pend_v) begin
                pend_v = 1'b0;
                start_frame(pend_w);
            end
`ifdef DAC_TX_CHANGE_DETECT_EN
            else if (d != last_sent_m) begin
                start_frame(d);
            end
`endif
        end else begin
            if (ld) begin
                ovr    = pend_v;
                pend_v = 1'b1;
                pend_w = d;
            end
            rem--;
        end
        exp_ovr = ovr;
    endtask

    // One CLK cycle: drive, compare at the falling edge, decode the bus, advance the model.
    task automatic cycle(input logic ld, input logic [15:0] d);
        logic [5:0] act, expv;
        int         i, half;
        logic [3:0] bi;
        logic       e_sclk, e_din;
        if (sel == 0) begin load_a = ld; din_a = d; end
        else begin load_b = ld; din_b = d; end
        @(negedge clk);
        act = (sel == 0) ? o_a : o_b;
        if (rem > hold_m) begin
            i      = 32 * div_m + hold_m - rem;
            half   = i / div_m;
            bi     = 4'(15 - half / 2);
            e_sclk = ((half % 2) == 0);
            e_din  = cur_w[bi];
        end else begin
            e_sclk = 1'b1;
            e_din  = 1'b0;
        end
        expv = {(rem > 0), (rem == hold_m), exp_ovr, !(rem > hold_m), e_sclk, e_din};
        check("cycle_outputs", act, expv);
        {s_busy, s_done, s_ovr, s_sync, s_sclk, s_din} = act;
        s_fell = !s_sync && prev_sclk && !s_sclk;
        if (s_busy) busy_seen++;
        if (s_ovr) ovr_seen++;
        if (s_fell) begin
            rx_w = {rx_w[14:0], s_din};
            rx_cnt++;
        end
        if (!prev_sync && s_sync) begin
            frames++;
            check("frame_bits", rx_cnt, 16);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected: got word %h, required no frame", rx_w);
            end else begin
                check("frame_word", rx_w, exp_q.pop_front());
            end
            last_rx = rx_w;
            rx_cnt  = 0;
        end
        prev_sclk = s_sclk;
        prev_sync = s_sync;
        @(posedge clk);
        model_edge(ld, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, (sel == 0) ? din_a : din_b);
    endtask

    task automatic do_reset(input int s);
        rst_n  = 1'b0;
        load_a = 1'b0;
        load_b = 1'b0;
        din_a  = 16'hFFFF;
        din_b  = 16'hFFFF;
        sel    = s;
        div_m  = (s == 0) ? DIV_A : DIV_B;
        hold_m = (s == 0) ? HOLD_A : HOLD_B;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", (s == 0) ? o_a : o_b, 6'b000110);
        check("reset_state", (s == 0) ? st_a : st_b, 2'd0);
        rem         = 0;
        pend_v      = 1'b0;
        exp_ovr     = 1'b0;
        last_sent_m = 16'hFFFF;
        cur_w       = '0;
        exp_q.delete();
        prev_sclk   = 1'b1;
        prev_sync   = 1'b1;
        rx_cnt      = 0;
        rst_n       = 1'b1;
    endtask

    initial begin
        vec_t        vecs[4];
        int          sl, fl, da, bc, tg, f0;
        logic        b131, b132, ps;
        logic [15:0] cur;
        logic        ld;

        vecs[0] = '{16'h47FF, 16'h47FF, 128, 16, 129, 130};
        vecs[1] = '{16'h0000, 16'h0000, 128, 16, 129, 130};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 128, 16, 129, 130};
        vecs[3] = '{16'hA5A5, 16'hA5A5, 128, 16, 129, 130};

        do_reset(0);
        idle(3);

        for (int v = 0; v < 4; v++) begin
            sl = 0; fl = 0; da = -1; bc = 0;
            last_rx = ~vecs[v].exp_word;
            cycle(1'b1, vecs[v].din);
            for (int t = 1; t <= 140; t++) begin
                cycle(1'b0, vecs[v].din);
                if (!s_sync) sl++;
                if (s_fell) fl++;
                if (s_done) da = t;
                if (s_busy) bc++;
            end
            check("vec_word", last_rx, vecs[v].exp_word);
            check("vec_sync_low", sl, vecs[v].exp_sync_low);
            check("vec_sclk_falls", fl, vecs[v].exp_falls);
            check("vec_done_cycle", da, vecs[v].exp_done_at);
            check("vec_busy_len", bc, vecs[v].exp_busy);
        end

        // Second Load mid-frame is queued and starts right after Busy drops.
        ovr_seen = 0; f0 = frames; b131 = 1'bx; b132 = 1'bx;
        cycle(1'b1, 16'h0123);
        for (int t = 1; t < 50; t++) cycle(1'b0, 16'h0123);
        cycle(1'b1, 16'h8ABC);
        for (int t = 51; t <= 280; t++) begin
            cycle(1'b0, 16'h8ABC);
            if (t == 131) b131 = s_busy;
            if (t == 132) b132 = s_busy;
        end
        check("b2b_gap_idle", b131, 1'b0);
        check("b2b_second_busy", b132, 1'b1);
        check("b2b_no_overrun", ovr_seen, 0);
        check("b2b_frames", frames - f0, 2);
        check("b2b_word", last_rx, 16'h8ABC);

        // Two Loads during a frame: the later word survives, one Overrun pulse.
        ovr_seen = 0; f0 = frames;
        cycle(1'b1, 16'h0F0F);
        for (int t = 1; t < 10; t++) cycle(1'b0, 16'h0F0F);
        cycle(1'b1, 16'h1111);
        for (int t = 11; t < 20; t++) cycle(1'b0, 16'h1111);
        cycle(1'b1, 16'h2222);
        for (int t = 21; t <= 280; t++) cycle(1'b0, 16'h2222);
        check("ovr_pulses", ovr_seen, 1);
        check("ovr_frames", frames - f0, 2);
        check("ovr_word", last_rx, 16'h2222);

        // Reset 40 cycles into a frame, observed without any clock edge.
        cycle(1'b1, 16'h5A5A);
        for (int t = 1; t < 40; t++) cycle(1'b0, 16'h5A5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", o_a, 6'b000110);
        check("rst_async_state", st_a, 2'd0);
        do_reset(0);
        f0 = frames;
        cycle(1'b1, 16'hC3C3);
        idle(140);
        check("rst_after_frames", frames - f0, 1);
        check("rst_after_word", last_rx, 16'hC3C3);

        // Fastest divider: SCLK toggles each cycle, Busy is 33 cycles.
        do_reset(1);
        bc = 0; fl = 0; tg = 0; da = -1; ps = 1'b1;
        cycle(1'b1, 16'hFFFF);
        for (int t = 1; t <= 40; t++) begin
            cycle(1'b0, 16'hFFFF);
            if (s_busy) bc++;
            if (s_fell) fl++;
            if (s_done) da = t;
            if (!s_sync && t > 1 && s_sclk != ps) tg++;
            ps = s_sclk;
        end
        check("div1_busy_len", bc, 33);
        check("div1_falls", fl, 16);
        check("div1_toggles", tg, 31);
        check("div1_done_cycle", da, 33);
        check("div1_word", last_rx, 16'hFFFF);

        cur = 16'hFFFF;
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 7) == 0) cur = 16'($urandom);
            ld = ($urandom_range(0, 19) == 0);
            cycle(ld, cur);
        end
        idle(150);
        check("div1_rand_drained", exp_q.size(), 0);

        do_reset(0);
`ifdef DAC_TX_CHANGE_DETECT_EN
        f0 = frames;
        cycle(1'b0, 16'h07FF);
        idle(200);
        check("cd_first_change", frames - f0, 1);
        f0 = frames;
        cycle(1'b0, 16'h0800);
        idle(200);
        check("cd_second_change", frames - f0, 1);
        check("cd_word", last_rx, 16'h0800);
        f0 = frames;
        idle(300);
        check("cd_constant_quiet", frames - f0, 0);
`else
        f0 = frames; busy_seen = 0;
        cycle(1'b0, 16'h07FF);
        idle(150);
        cycle(1'b0, 16'h0800);
        idle(150);
        check("nocd_no_frames", frames - f0, 0);
        check("nocd_never_busy", busy_seen, 0);
`endif

        do_reset(0);
        cur = 16'hFFFF;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 15) == 0) cur = 16'($urandom);
            ld = ($urandom_range(0, 59) == 0);
            cycle(ld, cur);
        end
        idle(500);
        check("rand_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
